// File: rtl/parser_pkg.sv
// parser_pkg: shared types and constants for the parser/deparser config table and FSM.
package parser_pkg;
    localparam int MAX_OFFSET_WIDTH = 16;
    localparam logic [31:0] CONF_ADDR_STATS = 32'h80;
    localparam int CONF_EN_BIT = 31;

    typedef logic [MAX_OFFSET_WIDTH-1:0] key_offset_t;

    typedef struct packed {
        logic        en;
        key_offset_t offset;
    } field_entry_t;

    typedef enum logic [1:0] {IDLE, WRITE, OUT} state_t;
endpackage

// File: rtl/phv_deparser_conf.sv
// deparser_conf: per-field offset/enable table with 32-bit config access.
// DEPARSER_STATS_EN adds an output-PHV counter at CONF_ADDR_STATS.
module deparser_conf
    import parser_pkg::*;
#(
    parameter int KEY_FIELD_NUM    = 8,
    parameter int KEY_OFFSET_WIDTH = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wren,
    input  logic                             rden,
    input  logic [31:0]                      addr,
    input  logic [31:0]                      wdata,
    input  logic                             stat_inc,
    output logic                             rdata_valid,
    output logic [31:0]                      rdata,
    output field_entry_t [KEY_FIELD_NUM-1:0] entries
);
    localparam int IW = KEY_FIELD_NUM > 1 ? $clog2(KEY_FIELD_NUM) : 1;

    logic         in_range;
    logic [IW-1:0] idx;
    field_entry_t wr_entry;
    field_entry_t rd_entry;
    logic [31:0]  entry_word;
    logic [31:0]  rd_word;
    logic         unused;

    assign in_range   = addr < 32'(KEY_FIELD_NUM);
    assign idx        = addr[IW-1:0];
    assign wr_entry   = '{en: wdata[CONF_EN_BIT], offset: key_offset_t'(wdata[KEY_OFFSET_WIDTH-1:0])};
    assign rd_entry   = entries[idx];
    assign entry_word = 32'(rd_entry.offset) | (32'(rd_entry.en) << CONF_EN_BIT);

`ifdef DEPARSER_STATS_EN
    logic [31:0] stats;
    logic        stats_hit;

    assign stats_hit = wren && addr == CONF_ADDR_STATS;
    assign rd_word   = in_range ? entry_word : addr == CONF_ADDR_STATS ? stats : '0;
    assign unused    = ^wdata;

    // A clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || stats_hit) stats <= '0;
        else if (stat_inc) stats <= stats + 32'd1;
    end
`else
    assign rd_word = in_range ? entry_word : '0;
    assign unused  = ^{wdata, stat_inc};
`endif

    // Read data is taken from the pre-write table, so a same-cycle write returns the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            entries     <= '0;
            rdata_valid <= 1'b0;
            rdata       <= '0;
        end else begin
            if (wren && in_range) entries[idx] <= wr_entry;
            rdata_valid <= rden;
            if (rden) rdata <= rd_word;
        end
    end
endmodule

// File: rtl/phv_deparser.sv
// phv_deparser: writes enabled metadata key fields back into the PHV, one field per cycle.
// Define DEPARSER_STATS_EN to enable the output-PHV counter in the config block.
module phv_deparser
    import parser_pkg::*;
#(
    parameter int PHV_WIDTH        = 1024,
    parameter int KEY_FIELD_WIDTH  = 16,
    parameter int KEY_FIELD_NUM    = 8,
    parameter int KEY_OFFSET_WIDTH = $clog2(PHV_WIDTH / KEY_FIELD_WIDTH),
    parameter int META_WIDTH       = 128
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_conf_wren,
    input  logic                  i_conf_rden,
    input  logic [31:0]           i_conf_addr,
    input  logic [31:0]           i_conf_wdata,
    output logic                  o_conf_rdata_valid,
    output logic [31:0]           o_conf_rdata,
    input  logic                  i_phv_in_valid,
    output logic                  o_phv_in_ready,
    input  logic [PHV_WIDTH-1:0]  i_phv_in,
    input  logic [META_WIDTH-1:0] i_meta_in,
    output logic                  o_phv_out_valid,
    input  logic                  i_phv_out_ready,
    output logic [PHV_WIDTH-1:0]  o_phv_out
);
    localparam int KW = KEY_FIELD_NUM > 1 ? $clog2(KEY_FIELD_NUM) : 1;

    // Offsets can never exceed the PHV only if the field count is an exact power of two.
    if ((PHV_WIDTH % KEY_FIELD_WIDTH) != 0 ||
        (1 << KEY_OFFSET_WIDTH) != PHV_WIDTH / KEY_FIELD_WIDTH ||
        KEY_OFFSET_WIDTH > MAX_OFFSET_WIDTH ||
        META_WIDTH < KEY_FIELD_NUM * KEY_FIELD_WIDTH) begin : g_bad_params
        $error("phv_deparser: inconsistent parameters");
    end

    field_entry_t [KEY_FIELD_NUM-1:0] entries;
    field_entry_t [KEY_FIELD_NUM-1:0] snap;
    state_t                           state;
    state_t                           state_nx;
    logic [PHV_WIDTH-1:0]             phv;
    logic [META_WIDTH-1:0]            meta;
    logic [KW-1:0]                    k;
    logic                             accept;
    logic                             last;

    deparser_conf #(
        .KEY_FIELD_NUM    (KEY_FIELD_NUM),
        .KEY_OFFSET_WIDTH (KEY_OFFSET_WIDTH)
    ) u_conf (
        .clk         (i_clk),
        .rst         (i_rst),
        .wren        (i_conf_wren),
        .rden        (i_conf_rden),
        .addr        (i_conf_addr),
        .wdata       (i_conf_wdata),
        .stat_inc    (o_phv_out_valid & i_phv_out_ready),
        .rdata_valid (o_conf_rdata_valid),
        .rdata       (o_conf_rdata),
        .entries     (entries)
    );

    assign accept          = state == IDLE && i_phv_in_valid;
    assign last            = k == KW'(KEY_FIELD_NUM - 1);
    assign o_phv_in_ready  = state == IDLE;
    assign o_phv_out_valid = state == OUT;
    assign o_phv_out       = phv;

    always_comb begin
        state_nx = accept ? WRITE :
                   (state == WRITE && last) ? OUT :
                   (state == OUT && i_phv_out_ready) ? IDLE : state;
    end

    // The table snapshot isolates the in-flight PHV from concurrent config writes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            phv   <= '0;
            meta  <= '0;
            snap  <= '0;
            k     <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                phv  <= i_phv_in;
                meta <= i_meta_in;
                snap <= entries;
                k    <= '0;
            end else if (state == WRITE) begin
                if (snap[k].en)
                    phv[int'(snap[k].offset) * KEY_FIELD_WIDTH +: KEY_FIELD_WIDTH] <=
                        meta[int'(k) * KEY_FIELD_WIDTH +: KEY_FIELD_WIDTH];
                k <= k + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_phv_deparser.sv
// tb_phv_deparser: directed self-checking bench for phv_deparser (default parameters).
// Stats checks follow DEPARSER_STATS_EN.
module tb_phv_deparser;
    logic          clk;
    logic          rst;
    logic          conf_wren;
    logic          conf_rden;
    logic [31:0]   conf_addr;
    logic [31:0]   conf_wdata;
    logic          conf_rdata_valid;
    logic [31:0]   conf_rdata;
    logic          phv_in_valid;
    logic          phv_in_ready;
    logic [1023:0] phv_in;
    logic [127:0]  meta_in;
    logic          phv_out_valid;
    logic          phv_out_ready;
    logic [1023:0] phv_out;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int cyc0   = 0;

    logic [1023:0] exp_phv;
    logic [1023:0] held_phv;

    phv_deparser dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_conf_wren        (conf_wren),
        .i_conf_rden        (conf_rden),
        .i_conf_addr        (conf_addr),
        .i_conf_wdata       (conf_wdata),
        .o_conf_rdata_valid (conf_rdata_valid),
        .o_conf_rdata       (conf_rdata),
        .i_phv_in_valid     (phv_in_valid),
        .o_phv_in_ready     (phv_in_ready),
        .i_phv_in           (phv_in),
        .i_meta_in          (meta_in),
        .o_phv_out_valid    (phv_out_valid),
        .i_phv_out_ready    (phv_out_ready),
        .o_phv_out          (phv_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_phv(input string tag, input logic [1023:0] exp);
        int bad;
        n_chk++;
        assert (phv_out === exp) else begin
            n_fail++;
            bad = -1;
            for (int j = 63; j >= 0; j--)
                if (phv_out[j*16 +: 16] !== exp[j*16 +: 16]) bad = j;
            if (bad < 0) bad = 0;
            $error("FAIL %s: phv field %0d got %h expected %h", tag, bad,
                   phv_out[bad*16 +: 16], exp[bad*16 +: 16]);
        end
    endtask

    task automatic cfg_write(input logic [31:0] a, input logic [31:0] d);
        conf_addr  = a;
        conf_wdata = d;
        conf_wren  = 1'b1;
        @(negedge clk);
        conf_wren  = 1'b0;
    endtask

    task automatic cfg_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        conf_addr = a;
        conf_rden = 1'b1;
        @(negedge clk);
        conf_rden = 1'b0;
        check({tag, "_vld"}, 64'(conf_rdata_valid), 64'd1);
        check({tag, "_data"}, 64'(conf_rdata), 64'(exp));
        @(negedge clk);
        check({tag, "_vld_drop"}, 64'(conf_rdata_valid), 64'd0);
    endtask

    task automatic send(input logic [1023:0] p, input logic [127:0] m);
        int n;
        phv_in       = p;
        meta_in      = m;
        phv_in_valid = 1'b1;
        n = 0;
        while (!phv_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!phv_in_ready) check("send_ready_timeout", 64'(phv_in_ready), 64'd1);
        cyc0 = cyc;
        @(negedge clk);
        phv_in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input logic [1023:0] exp);
        int n;
        n = 0;
        while (!phv_out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(cyc - cyc0), 64'd9);
        check_phv(tag, exp);
    endtask

    task automatic release_out(input string tag);
        phv_out_ready = 1'b1;
        @(negedge clk);
        phv_out_ready = 1'b0;
        check({tag, "_rel_valid"}, 64'(phv_out_valid), 64'd0);
        check({tag, "_rel_ready"}, 64'(phv_in_ready), 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        conf_wren = 1'b0;
        conf_rden = 1'b0;
        conf_addr = '0;
        conf_wdata = '0;
        phv_in_valid = 1'b0;
        phv_in = '0;
        meta_in = '0;
        phv_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(phv_in_ready), 64'd1);
        check("rst_out_valid", 64'(phv_out_valid), 64'd0);
        check("rst_rdata_valid", 64'(conf_rdata_valid), 64'd0);
        check("rst_rdata", 64'(conf_rdata), 64'd0);
        check_phv("rst_phv_out", '0);
        rst = 1'b0;
        @(negedge clk);

        // Config map: enable/offset, masked junk bits, out-of-range, read-during-write.
        cfg_write(0, 32'h8000_0002);
        cfg_write(1, 32'h8000_0005);
        cfg_write(2, 32'h7FFF_FFC3);
        cfg_write(8, 32'h8000_0001);
        cfg_read("rd_e0", 0, 32'h8000_0002);
        cfg_read("rd_e2_masked", 2, 32'h0000_0003);
        cfg_read("rd_addr8", 8, 32'h0);
        cfg_read("rd_addr9", 9, 32'h0);
        conf_addr  = 1;
        conf_wdata = 32'h8000_000F;
        conf_wren  = 1'b1;
        conf_rden  = 1'b1;
        @(negedge clk);
        conf_wren = 1'b0;
        conf_rden = 1'b0;
        check("rdw_old_value", 64'(conf_rdata), 64'h8000_0005);
        @(negedge clk);
        cfg_read("rd_e1_new", 1, 32'h8000_000F);
        cfg_write(1, 32'h8000_0005);

        // Two enabled fields into a zero PHV.
        meta_in = '0;
        meta_in[15:0]   = 16'hAAAA;
        meta_in[31:16]  = 16'h5555;
        meta_in[47:32]  = 16'h1234;
        meta_in[127:112] = 16'h9999;
        send('0, meta_in);
        check("write_in_ready", 64'(phv_in_ready), 64'd0);
        exp_phv = '0;
        exp_phv[47:32] = 16'hAAAA;
        exp_phv[95:80] = 16'h5555;
        wait_out("t1", exp_phv);
        release_out("t1");

        // Overlapping offsets: the higher field index wins, other bits pass through.
        cfg_write(0, 32'h0);
        cfg_write(1, 32'h0);
        cfg_write(3, 32'h8000_000A);
        cfg_write(6, 32'h8000_000A);
        phv_in = {64{16'hC3C3}};
        for (int j = 0; j < 8; j++) meta_in[j*16 +: 16] = 16'h1111 * 16'(j + 1);
        exp_phv = {64{16'hC3C3}};
        exp_phv[175:160] = 16'h7777;
        send(phv_in, meta_in);
        wait_out("t2_overlap", exp_phv);
        release_out("t2");

        // Rewrite during WRITE must not disturb the in-flight PHV.
        cfg_write(3, 32'h0);
        cfg_write(6, 32'h0);
        cfg_write(0, 32'h8000_0002);
        meta_in = '0;
        meta_in[15:0] = 16'hBEEF;
        send('0, meta_in);
        cfg_write(0, 32'h8000_0007);
        exp_phv = '0;
        exp_phv[47:32] = 16'hBEEF;
        wait_out("t3_snapshot", exp_phv);
        release_out("t3a");
        meta_in[15:0] = 16'hCAFE;
        send('0, meta_in);
        exp_phv = '0;
        exp_phv[127:112] = 16'hCAFE;
        wait_out("t3_new_off", exp_phv);
        release_out("t3b");

        // Backpressure: output holds, no accept until the IDLE cycle after the handshake.
        meta_in = '0;
        send('1, meta_in);
        exp_phv = '1;
        exp_phv[127:112] = 16'h0000;
        wait_out("t4_first", exp_phv);
        held_phv = exp_phv;
        phv_in_valid = 1'b1;
        phv_in = '0;
        meta_in[15:0] = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(phv_out_valid), 64'd1);
            check("bp_in_ready", 64'(phv_in_ready), 64'd0);
            check_phv("bp_stable", held_phv);
        end
        phv_out_ready = 1'b1;
        @(negedge clk);
        phv_out_ready = 1'b0;
        check("bp_idle_valid", 64'(phv_out_valid), 64'd0);
        check("bp_idle_ready", 64'(phv_in_ready), 64'd1);
        cyc0 = cyc;
        @(negedge clk);
        phv_in_valid = 1'b0;
        check("bp_accepted", 64'(phv_in_ready), 64'd0);
        exp_phv = '0;
        exp_phv[127:112] = 16'h1234;
        wait_out("t4_second", exp_phv);
        release_out("t4");

        // Reset in the middle of WRITE drops the PHV and clears the table.
        send('1, meta_in);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstw_out_valid", 64'(phv_out_valid), 64'd0);
        check("rstw_in_ready", 64'(phv_in_ready), 64'd1);
        cfg_read("rstw_e0", 0, 32'h0);
        cfg_read("rstw_addr9", 9, 32'h0);
        repeat (10) @(negedge clk);
        check("rstw_no_out", 64'(phv_out_valid), 64'd0);

        // All entries disabled: pass-through, three PHVs for the counter.
        for (int i = 0; i < 3; i++) begin
            phv_in = {32{32'h0F1E_2D3C ^ 32'(i)}};
            exp_phv = phv_in;
            send(phv_in, {8{16'hFFFF}});
            wait_out("pass", exp_phv);
            release_out("pass");
        end
`ifdef DEPARSER_STATS_EN
        cfg_read("stats_3", 32'h80, 32'd3);
        cfg_write(32'h80, 32'h0);
        cfg_read("stats_clr", 32'h80, 32'd0);
`else
        cfg_read("stats_absent", 32'h80, 32'd0);
        cfg_write(32'h80, 32'hFFFF_FFFF);
        cfg_read("stats_absent_wr", 32'h80, 32'd0);
        cfg_read("no_alias_e0", 0, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
